// File: rtl/conv_encoder_param.sv
// conv_encoder_param
//   Rate-1/N feed-forward convolutional encoder with configurable constraint
//   length K, N output streams and per-stream generator polynomials. One input
//   bit per step yields one N-bit codeword. The codeword is held in an output
//   register, so a codeword appears one cycle after its bit is accepted. With
//   TERMINATE=1 every frame is flushed by K-1 zero tail bits after in_last,
//   which returns the window to the all-zero state.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   input bit valid
//   in_ready   encoder accepts in_data this cycle
//   in_data    information bit
//   in_last    final information bit of the frame (qualified by in_valid)
//   out_valid  codeword valid
//   out_ready  downstream accepts the codeword
//   out_data   codeword, bit j = parity of generator j over the window
//   out_last   final codeword of the frame
//   out_tail   codeword produced by a tail (zero) bit
module conv_encoder_param #(
  parameter int K         = 13,
  parameter int N         = 2,
  parameter     GENS      = {13'h11BF, 13'h1B51},
  parameter bit TERMINATE = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         out_tail
);

  localparam int TW = $clog2(K);
  localparam logic [N*K-1:0] GEN_VEC = GENS;

  // Elaboration-time parameter sanity checks.
  if (K < 3 || K > 32) begin : g_bad_k
    $error("conv_encoder_param: K must be in 3..32");
  end
  if (N < 2 || N > 8) begin : g_bad_n
    $error("conv_encoder_param: N must be in 2..8");
  end
  if ($bits(GENS) != N * K) begin : g_bad_width
    $error("conv_encoder_param: GENS width must equal N*K");
  end
  for (genvar g = 0; g < N; g++) begin : g_gen_chk
    // A generator without its first or last tap would shorten the effective
    // constraint length and break tail termination.
    if (GEN_VEC[g*K] == 1'b0 || GEN_VEC[g*K+K-1] == 1'b0) begin : g_bad_taps
      $error("conv_encoder_param: generator must have bit 0 and bit K-1 set");
    end
  end

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TAIL = 1'b1
  } state_t;

  state_t         state_q, state_d;
  // Only the K-1 previous bits are stored; the current bit comes from the input.
  logic [K-2:0]   hist_q, hist_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_data_q, out_data_d;
  logic           out_last_q, out_last_d;
  logic           out_tail_q, out_tail_d;

  logic           slot_free;
  logic           step;
  logic           bit_in;
  logic [K-1:0]   win;
  logic [N-1:0]   parity;

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    tcnt_d      = tcnt_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_tail_d  = out_tail_q;
    // A handshaken codeword is retired unless a new step replaces it below.
    out_valid_d = out_valid_q && !out_ready;
    in_ready    = 1'b0;
    step        = 1'b0;
    bit_in      = 1'b0;
    parity      = '0;

    // The output register can take a new codeword if it is empty or draining.
    slot_free = !out_valid_q || out_ready;

    case (state_q)
      ST_RUN: begin
        in_ready = slot_free;
        step     = in_valid && slot_free;
        bit_in   = in_data;
      end
      default: begin
        // Tail: feed zeros without consuming input.
        step = slot_free;
      end
    endcase

    win = {hist_q, bit_in};
    for (int j = 0; j < N; j++) begin
      parity[j] = ^(GEN_VEC[j*K +: K] & win);
    end

    if (step) begin
      out_valid_d = 1'b1;
      out_data_d  = parity;
      hist_d      = win[K-2:0];
      if (state_q == ST_RUN) begin
        out_tail_d = 1'b0;
        out_last_d = 1'b0;
        if (in_last) begin
          if (TERMINATE) begin
            tcnt_d  = TW'(K - 2);
            state_d = ST_TAIL;
          end else begin
            // Streaming mode: mark the frame end but keep the window running.
            out_last_d = 1'b1;
          end
        end
      end else begin
        out_tail_d = 1'b1;
        out_last_d = (tcnt_q == '0);
        tcnt_d     = tcnt_q - 1'b1;
        if (tcnt_q == '0) begin
          // Final tail bit: start the next frame from the zero state.
          tcnt_d  = '0;
          hist_d  = '0;
          state_d = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      hist_q      <= '0;
      tcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_tail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      tcnt_q      <= tcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_tail_q  <= out_tail_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_tail  = out_tail_q;

endmodule

// File: tb/tb_conv_encoder_param.sv
// Testbench for conv_encoder_param: default K=13 rate-1/2 encoder with and
// without termination, plus a K=3 rate-1/3 configuration.
module tb_conv_encoder_param;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Default config, TERMINATE=1
  logic       a_in_valid, a_in_ready, a_in_data, a_in_last;
  logic       a_out_valid, a_out_ready, a_out_last, a_out_tail;
  logic [1:0] a_out_data;
  // Default config, TERMINATE=0
  logic       b_in_valid, b_in_ready, b_in_data, b_in_last;
  logic       b_out_valid, b_out_ready, b_out_last, b_out_tail;
  logic [1:0] b_out_data;
  // K=3, N=3
  logic       c_in_valid, c_in_ready, c_in_data, c_in_last;
  logic       c_out_valid, c_out_ready, c_out_last, c_out_tail;
  logic [2:0] c_out_data;

  conv_encoder_param dut_a (
    .clock(clock), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .out_tail(a_out_tail)
  );

  conv_encoder_param #(.TERMINATE(1'b0)) dut_b (
    .clock(clock), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .out_tail(b_out_tail)
  );

  conv_encoder_param #(.K(3), .N(3), .GENS({3'b111, 3'b101, 3'b111}), .TERMINATE(1'b1)) dut_c (
    .clock(clock), .reset(reset),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_last(c_in_last),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_last(c_out_last), .out_tail(c_out_tail)
  );

  typedef struct packed {
    logic [1:0] data;
    logic       tail;
    logic       last;
  } cw_t;

  typedef struct {
    logic       v, d, l, r;
    logic       e_ov;
    logic [2:0] e_data;
    logic       e_tail, e_last, e_ir;
  } row_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   hs_a   = 0;
  cw_t  exp_a[$];
  int   hs_cyc_q[$];
  logic hs_last_q[$];
  logic prev_stall_a = 1'b0;
  cw_t  prev_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the legacy fixed K=13 rate-1/2 equations.
  function automatic logic [1:0] leg(input logic [12:0] w);
    logic p0, p1;
    p0 = w[0] ^ w[4] ^ w[6] ^ w[8] ^ w[9] ^ w[11] ^ w[12];
    p1 = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4] ^ w[5] ^ w[7] ^ w[8] ^ w[12];
    return {p1, p0};
  endfunction

  // Expected codewords of one terminated frame, starting from the zero state.
  task automatic push_frame_a(input logic [31:0] bits, input int len);
    logic [11:0] h;
    h = '0;
    for (int i = 0; i < len; i++) begin
      exp_a.push_back('{data: leg({h, bits[i]}), tail: 1'b0, last: 1'b0});
      h = {h[10:0], bits[i]};
    end
    for (int t = 0; t < 12; t++) begin
      exp_a.push_back('{data: leg({h, 1'b0}), tail: 1'b1, last: (t == 11)});
      h = {h[10:0], 1'b0};
    end
  endtask

  // One cycle on dut_a: drive at negedge, sample 1 time unit later.
  task automatic step_a(input logic v, input logic d, input logic l, input logic r,
                        output logic acc, output logic hs);
    cw_t cur, e;
    @(negedge clock);
    a_in_valid = v; a_in_data = d; a_in_last = l; a_out_ready = r;
    #1;
    cyc++;
    acc = v && a_in_ready;
    hs  = a_out_valid && r;
    cur = {a_out_data, a_out_tail, a_out_last};
    if (a_out_valid && !r) chk("a_stall_in_ready", a_in_ready, 0);
    if (prev_stall_a) begin
      chk("a_hold_valid", a_out_valid, 1);
      chk("a_hold_cw", cur, prev_a);
    end
    if (hs) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_extra_cw: got %0h expected none", cur);
      end else begin
        e = exp_a.pop_front();
        chk("a_cw", cur, e);
      end
      hs_a++;
      hs_cyc_q.push_back(cyc);
      hs_last_q.push_back(a_out_last);
    end
    prev_stall_a = a_out_valid && !r;
    prev_a = cur;
  endtask

  task automatic send_stream_a(input logic [31:0] bits, input logic [31:0] lastm, input int len,
                               input bit bp, input int n_hs, input string name);
    int   idx, k, start;
    logic v, d, l, r, acc, hs;
    idx = 0; k = 0; start = hs_a;
    while ((hs_a - start) < n_hs && k < 400) begin
      v = (idx < len);
      d = v ? bits[idx] : 1'b0;
      l = v ? lastm[idx] : 1'b0;
      r = bp ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
      step_a(v, d, l, r, acc, hs);
      if (acc) idx++;
      k++;
    end
    chk({name, "_handshakes"}, hs_a - start, n_hs);
    chk({name, "_accepted"}, idx, len);
    chk({name, "_leftover"}, exp_a.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    row_t        t1[15];
    row_t        t5[7];
    logic [1:0]  imp[13];
    logic        acc, hs;
    int          tails, n, i0;
    logic [11:0] h_b;
    cw_t         exp_b[$];
    cw_t         eb, cur_b;
    int          acc_b, hs_b;
    logic        v, d, l, r;

    imp = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b01,
            2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11};

    // Impulse table: first row presents the bit, then 13 codewords, then idle.
    t1[0] = '{v: 1, d: 1, l: 1, r: 1, e_ov: 0, e_data: 0, e_tail: 0, e_last: 0, e_ir: 1};
    for (int i = 1; i <= 13; i++) begin
      t1[i] = '{v: 0, d: 0, l: 0, r: 1, e_ov: 1, e_data: {1'b0, imp[i-1]},
                e_tail: (i >= 2), e_last: (i == 13), e_ir: (i == 13)};
    end
    t1[14] = '{v: 0, d: 0, l: 0, r: 1, e_ov: 0, e_data: 0, e_tail: 0, e_last: 0, e_ir: 1};

    // K=3 table, input 1,0,1 with last on the third bit.
    t5[0] = '{v: 1, d: 1, l: 0, r: 1, e_ov: 0, e_data: 3'b000, e_tail: 0, e_last: 0, e_ir: 1};
    t5[1] = '{v: 1, d: 0, l: 0, r: 1, e_ov: 1, e_data: 3'b111, e_tail: 0, e_last: 0, e_ir: 1};
    t5[2] = '{v: 1, d: 1, l: 1, r: 1, e_ov: 1, e_data: 3'b101, e_tail: 0, e_last: 0, e_ir: 1};
    t5[3] = '{v: 0, d: 0, l: 0, r: 1, e_ov: 1, e_data: 3'b000, e_tail: 0, e_last: 0, e_ir: 0};
    t5[4] = '{v: 0, d: 0, l: 0, r: 1, e_ov: 1, e_data: 3'b101, e_tail: 1, e_last: 0, e_ir: 0};
    t5[5] = '{v: 0, d: 0, l: 0, r: 1, e_ov: 1, e_data: 3'b111, e_tail: 1, e_last: 1, e_ir: 1};
    t5[6] = '{v: 0, d: 0, l: 0, r: 1, e_ov: 0, e_data: 3'b000, e_tail: 0, e_last: 0, e_ir: 1};

    reset = 1'b1;
    a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 1;
    c_in_valid = 0; c_in_data = 0; c_in_last = 0; c_out_ready = 1;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_a_flags", {a_out_last, a_out_tail}, 0);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_c_valid", c_out_valid, 0);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_c_in_ready", c_in_ready, 1);

    // Impulse, cycle-accurate
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      a_in_valid = t1[i].v; a_in_data = t1[i].d; a_in_last = t1[i].l; a_out_ready = t1[i].r;
      #1;
      chk($sformatf("imp_valid_%0d", i), a_out_valid, t1[i].e_ov);
      chk($sformatf("imp_in_ready_%0d", i), a_in_ready, t1[i].e_ir);
      if (t1[i].e_ov) begin
        chk($sformatf("imp_data_%0d", i), a_out_data, t1[i].e_data[1:0]);
        chk($sformatf("imp_tail_%0d", i), a_out_tail, t1[i].e_tail);
        chk($sformatf("imp_last_%0d", i), a_out_last, t1[i].e_last);
      end
    end

    // Backpressure: frame 8'hA5 (LSB first) with out_ready pattern 1,0,0,1
    prev_stall_a = 1'b0;
    push_frame_a(32'hA5, 8);
    send_stream_a(32'hA5, 32'h80, 8, 1'b1, 20, "bp");

    // Reset in the middle of the tail
    push_frame_a(32'h1, 1);
    tails = 0; n = 0;
    while (tails < 5 && n < 50) begin
      step_a(n == 0, 1'b1, 1'b1, 1'b1, acc, hs);
      if (hs && a_out_tail) tails++;
      n++;
    end
    chk("midtail_tails_seen", tails, 5);
    @(negedge clock);
    reset = 1'b1; a_in_valid = 0;
    @(negedge clock);
    #1;
    chk("midtail_rst_valid", a_out_valid, 0);
    chk("midtail_rst_data", a_out_data, 0);
    chk("midtail_rst_flags", {a_out_last, a_out_tail}, 0);
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("midtail_in_ready", a_in_ready, 1);
    chk("midtail_valid_after", a_out_valid, 0);
    exp_a.delete();
    prev_stall_a = 1'b0;
    push_frame_a(32'h0, 1);
    send_stream_a(32'h0, 32'h1, 1, 1'b0, 13, "zero_frame");

    // Back-to-back frames, in_valid held high
    hs_cyc_q.delete();
    hs_last_q.delete();
    push_frame_a(32'hB, 4);
    push_frame_a(32'h6, 4);
    send_stream_a(32'h6B, 32'h88, 8, 1'b0, 32, "b2b");
    i0 = -1;
    for (int i = 0; i < hs_last_q.size(); i++) begin
      if (hs_last_q[i] && i0 < 0) i0 = i;
    end
    if (i0 >= 0 && hs_cyc_q.size() > i0 + 1) begin
      chk("b2b_first_last_index", i0, 15);
      chk("b2b_gap", hs_cyc_q[i0+1] - hs_cyc_q[i0], 1);
    end else begin
      checks++; errors++;
      $display("FAIL b2b_order: got last index %0d expected 15", i0);
    end

    // K=3, N=3 configuration
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      c_in_valid = t5[i].v; c_in_data = t5[i].d; c_in_last = t5[i].l; c_out_ready = t5[i].r;
      #1;
      chk($sformatf("k3_valid_%0d", i), c_out_valid, t5[i].e_ov);
      chk($sformatf("k3_in_ready_%0d", i), c_in_ready, t5[i].e_ir);
      if (t5[i].e_ov) begin
        chk($sformatf("k3_data_%0d", i), c_out_data, t5[i].e_data);
        chk($sformatf("k3_tail_%0d", i), c_out_tail, t5[i].e_tail);
        chk($sformatf("k3_last_%0d", i), c_out_last, t5[i].e_last);
      end
    end

    // Streaming without termination against the legacy equations
    h_b = '0; acc_b = 0; hs_b = 0; n = 0;
    while ((acc_b < 1000 || exp_b.size() != 0) && n < 6000) begin
      @(negedge clock);
      v = (acc_b < 1000) && ($urandom_range(0, 7) != 0);
      d = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 3) != 0);
      b_in_valid = v; b_in_data = d; b_in_last = l; b_out_ready = r;
      #1;
      n++;
      cur_b = {b_out_data, b_out_tail, b_out_last};
      if (b_out_valid && !r) chk("stream_stall_in_ready", b_in_ready, 0);
      if (b_out_valid && r) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_extra_cw: got %0h expected none", cur_b);
        end else begin
          eb = exp_b.pop_front();
          chk("stream_cw", cur_b, eb);
        end
        hs_b++;
      end
      if (v && b_in_ready) begin
        exp_b.push_back('{data: leg({h_b, d}), tail: 1'b0, last: l});
        h_b = {h_b[10:0], d};
        acc_b++;
      end
    end
    b_in_valid = 0;
    chk("stream_accepted", acc_b, 1000);
    chk("stream_handshakes", hs_b, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
